// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Optional parity bit compiled in when the PARITY_EN macro is defined.
module serial_pattern_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [DATA_W-1:0]  shreg_q, shreg_n;
  logic               ready_n, dout_n, busy_n, done_n;
  logic               bit_end;
`ifdef PARITY_EN
  logic               par_q, par_n;
`endif

  assign bit_end = (cnt_q == LAST_CNT);

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_ready <= 1'b0;
      dout     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      shreg_q  <= shreg_n;
      tx_ready <= ready_n;
      dout     <= dout_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // Next-state logic; counters clear on every state change
  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    idx_n   = '0;
    shreg_n = shreg_q;
`ifdef PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n = START;
          shreg_n = tx_data;
`ifdef PARITY_EN
          par_n   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
        else         cnt_n   = cnt_q + 1'b1;
      end
      DATA: begin
        idx_n = idx_q;
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
`ifdef PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
            idx_n   = '0;
          end else begin
            idx_n   = idx_q + 1'b1;
            shreg_n = shreg_q >> 1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
        else         cnt_n   = cnt_q + 1'b1;
      end
`endif
      STOP: begin
        if (bit_end) state_n = IDLE;
        else         cnt_n   = cnt_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are the Moore decode of the upcoming state, registered on the same edge
  always_comb begin
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == STOP) && (cnt_n == LAST_CNT);
    dout_n  = 1'b1;
    case (state_n)
      START:   dout_n = 1'b0;
      DATA:    dout_n = shreg_n[0];
`ifdef PARITY_EN
      PARITY:  dout_n = par_q;
`endif
      default: dout_n = 1'b1;
    endcase
  end

endmodule
